receiver_datapath: RTL and testbench
====================================

// Module: receiver_datapath
// PURPOSE
//  UART RX datapath paired with the receiver control FSM.
//  - Synchronises the raw RX line and times bit centres with a baud counter.
//  - Counts data bits and deserialises the byte, LSB first.
//  - Returns i_RX, i_equal and i_equal_MSB to the FSM and receives its one-hot state flags.
//  - Outputs a received byte with a one-cycle valid strobe, and a framing-error strobe.
// PARAMETERS
//  CLKS_PER_BIT  16  i_clock cycles per UART bit; even, >=4
//  DATA_BITS     8   data bits per frame; 5..8
// PORTS
//  i_clock            in   1          system clock, rising edge
//  i_resetL           in   1          asynchronous, active-low reset
//  i_RX_async         in   1          raw serial line, idle high
//  i_state_is_START   in   1          FSM in START
//  i_state_is_DATA    in   1          FSM in DATA
//  i_state_is_STOP    in   1          FSM in STOP (all three low = IDLE)
//  o_RX               out  1          synchronised RX to FSM i_RX
//  o_equal            out  1          bit-centre pulse to FSM i_equal
//  o_equal_MSB        out  1          last-data-bit flag to FSM i_equal_MSB
//  o_data             out  DATA_BITS  last good byte
//  o_data_valid       out  1          1-cycle strobe, o_data updated
//  o_framing_error    out  1          1-cycle strobe, stop bit sampled low
// BEHAVIOUR
//  Reset values (async, i_resetL low):
//   - sync flops = 1, o_RX = 1, counters = 0, shift reg = 0
//   - o_data = 0; o_equal, o_equal_MSB, o_data_valid, o_framing_error = 0
//  Synchroniser: 2 flops; o_RX = 2nd flop, so i_RX_async reaches o_RX in 2 cycles.
//  Baud counter cnt, width $clog2(CLKS_PER_BIT):
//   - IDLE: held at 0.
//   - Otherwise: increments each cycle.
//   - Terminal value: START = CLKS_PER_BIT/2-1 (start-bit centre); DATA/STOP = CLKS_PER_BIT-1.
//   - At terminal, cnt wraps to 0 on the next edge.
//  o_equal: combinational (non-IDLE && cnt==terminal); exactly one cycle wide.
//   The FSM delays it by half a cycle, so it stays glitch-free from registered cnt only.
//  Bit index bidx, width $clog2(DATA_BITS+1):
//   - Cleared whenever not DATA.
//   - In DATA, increments on each o_equal cycle.
//  o_equal_MSB: combinational (DATA && bidx==DATA_BITS-1).
//  Shift reg: in DATA on o_equal, sr <= {o_RX, sr[DATA_BITS-1:1]} (LSB first).
//  STOP on o_equal:
//   - o_RX==1: o_data <= sr, o_data_valid = 1 for 1 cycle.
//   - o_RX==0: o_framing_error = 1 for 1 cycle; o_data holds.
//  Flag priority if several are high (illegal): STOP > DATA > START.
//  State change lag: the FSM updates up to 1 cycle after o_equal. cnt has already wrapped,
//   and the first terminal of the new state is >=3 cycles away, so no pulse is lost.
//  Back-to-back frames: STOP->START reloads the START terminal, and cnt continues from its wrap.
//  Reset mid-frame: all state cleared at once; the next frame is received normally.
// CONFIGURATION
//  RX_ERROR_COUNT_EN defined:
//   - Adds port o_error_count, out, 8 bits.
//   - Counts o_framing_error strobes, saturates at 255, cleared only by i_resetL.
//  RX_ERROR_COUNT_EN undefined: no port, no counter logic.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, paired with the control FSM)
//  1. resetL low, RX toggling -> o_RX=1, o_equal=0, o_data=8'h00, valid=0, error=0.
//  2. Force START flag 10 cycles from IDLE -> one o_equal pulse at the 8th cycle (cnt=7); cnt then 0.
//  3. Frame 8'h55 + stop=1 -> o_data=8'h55, valid pulses once, ~152 cycles after the start edge.
//  4. Frame 8'hA3 + stop=0 -> framing_error pulses once, o_data stays 8'h55, no valid
//     (error_count=1 with EN).
//  5. Reset after 4 data bits, then frame 8'h0F -> all outputs cleared, then o_data=8'h0F valid.
//  6. With EN, 260 bad-stop frames -> o_error_count=255 saturated; reset -> 0.

Source files
------------

// File: rtl/receiver_datapath.sv
// UART RX datapath: line synchroniser, baud/bit counters and LSB-first deserialiser driven by the
// one-hot state flags of the receiver control FSM. Optional framing-error counter under RX_ERROR_COUNT_EN.
module receiver_datapath #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clock,
    input  logic                 i_resetL,
    input  logic                 i_RX_async,
    input  logic                 i_state_is_START,
    input  logic                 i_state_is_DATA,
    input  logic                 i_state_is_STOP,
    output logic                 o_RX,
    output logic                 o_equal,
    output logic                 o_equal_MSB,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_framing_error
`ifdef RX_ERROR_COUNT_EN
    ,
    output logic [7:0]           o_error_count
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] TERM_START = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] TERM_BIT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t                 state;
    logic                   rx_meta;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          terminal;
    logic [BW-1:0]          bidx;
    logic [DATA_BITS-1:0]   sr;

    // Illegal multi-hot flags resolve by priority STOP > DATA > START.
    always_comb begin
        state = ST_IDLE;
        if (i_state_is_STOP)       state = ST_STOP;
        else if (i_state_is_DATA)  state = ST_DATA;
        else if (i_state_is_START) state = ST_START;
    end

    // NOTE: o_equal is decoded only from registered cnt and the FSM flags, so it is a clean
    // one-cycle pulse; every state element below uses non-blocking assignments.
    always_comb begin
        terminal    = (state == ST_START) ? TERM_START : TERM_BIT;
        o_equal     = (state != ST_IDLE) && (cnt == terminal);
        o_equal_MSB = (state == ST_DATA) && (bidx == LAST_BIT);
    end

    // Synchroniser resets to the idle-high line level so no false start bit appears.
    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            rx_meta <= 1'b1;
            o_RX    <= 1'b1;
        end else begin
            rx_meta <= i_RX_async;
            o_RX    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            cnt <= '0;
        end else if (state == ST_IDLE || o_equal) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            bidx <= '0;
            sr   <= '0;
        end else if (state != ST_DATA) begin
            bidx <= '0;
        end else if (o_equal) begin
            bidx <= bidx + BW'(1);
            sr   <= {o_RX, sr[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            o_data          <= '0;
            o_data_valid    <= 1'b0;
            o_framing_error <= 1'b0;
        end else begin
            o_data_valid    <= (state == ST_STOP) && o_equal && o_RX;
            o_framing_error <= (state == ST_STOP) && o_equal && !o_RX;
            if ((state == ST_STOP) && o_equal && o_RX) begin
                o_data <= sr;
            end
        end
    end

`ifdef RX_ERROR_COUNT_EN
    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            o_error_count <= '0;
        end else if (o_framing_error && (o_error_count != 8'hFF)) begin
            o_error_count <= o_error_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_receiver_datapath.sv
// Directed bench for receiver_datapath with a behavioural receiver control FSM closing the loop.
// Build with +define+RX_ERROR_COUNT_EN to also exercise the saturating error counter.
module tb_receiver_datapath;

    logic       clk;
    logic       rst_l;
    logic       rx;
    logic       st_start, st_data, st_stop;
    logic       o_RX, o_equal, o_equal_MSB;
    logic [7:0] o_data;
    logic       o_data_valid, o_framing_error;
`ifdef RX_ERROR_COUNT_EN
    logic [7:0] o_error_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Directed override of the state flags vs. the behavioural FSM
    logic fsm_en  = 1'b0;
    logic f_start = 1'b0;

    typedef enum {F_IDLE, F_START, F_DATA, F_STOP} fsm_t;
    fsm_t fsm = F_IDLE;
    fsm_t fsm_nxt;

    // Event counters maintained by the monitor
    int cyc       = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int msb_cnt   = 0;
    int last_valid_cyc = 0;

    assign st_start = fsm_en ? (fsm == F_START) : f_start;
    assign st_data  = fsm_en && (fsm == F_DATA);
    assign st_stop  = fsm_en && (fsm == F_STOP);

    receiver_datapath #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .i_clock          (clk),
        .i_resetL         (rst_l),
        .i_RX_async       (rx),
        .i_state_is_START (st_start),
        .i_state_is_DATA  (st_data),
        .i_state_is_STOP  (st_stop),
        .o_RX             (o_RX),
        .o_equal          (o_equal),
        .o_equal_MSB      (o_equal_MSB),
        .o_data           (o_data),
        .o_data_valid     (o_data_valid),
        .o_framing_error  (o_framing_error)
`ifdef RX_ERROR_COUNT_EN
        ,
        .o_error_count    (o_error_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural control FSM: samples mid-cycle, updates just after the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            fsm_nxt = fsm;
            if (!rst_l || !fsm_en) begin
                fsm_nxt = F_IDLE;
            end else begin
                case (fsm)
                    F_IDLE:  if (!o_RX) fsm_nxt = F_START;
                    F_START: if (o_equal) fsm_nxt = o_RX ? F_IDLE : F_DATA;
                    F_DATA:  if (o_equal && o_equal_MSB) fsm_nxt = F_STOP;
                    F_STOP:  if (o_equal) fsm_nxt = F_IDLE;
                    default: fsm_nxt = F_IDLE;
                endcase
            end
            @(posedge clk);
            #1;
            fsm = (rst_l && fsm_en) ? fsm_nxt : F_IDLE;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (o_data_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (o_framing_error) ferr_cnt++;
            if (o_equal && o_equal_MSB) msb_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(16);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    // Holds START for ten cycles, reporting pulse count and the 1-based cycle of the last pulse.
    task automatic start_run(output int pulses, output int pos);
        pulses = 0;
        pos    = 0;
        f_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (o_equal) begin
                pulses++;
                pos = k;
            end
            @(posedge clk);
            #1;
        end
        f_start = 1'b0;
    endtask

    initial begin
        int pulses, pos;
        int v0, e0, m0, c0;

        // Reset with the line toggling
        rst_l = 1'b0;
        rx    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            tick(1);
        end
        check("reset_o_RX",        32'(o_RX),            32'd1);
        check("reset_o_equal",     32'(o_equal),         32'd0);
        check("reset_o_equal_MSB", 32'(o_equal_MSB),     32'd0);
        check("reset_o_data",      32'(o_data),          32'h00);
        check("reset_valid",       32'(o_data_valid),    32'd0);
        check("reset_ferr",        32'(o_framing_error), 32'd0);
        rx = 1'b1;
        tick(2);
        rst_l = 1'b1;
        tick(4);

        // START forced from IDLE: one pulse at cnt=7, then cnt restarts from 0 after IDLE
        start_run(pulses, pos);
        check("start_pulse_count", 32'(pulses), 32'd1);
        check("start_pulse_pos",   32'(pos),    32'd8);
        tick(1);
        start_run(pulses, pos);
        check("restart_pulse_count", 32'(pulses), 32'd1);
        check("restart_pulse_pos",   32'(pos),    32'd8);
        tick(4);

        // Good frame 0x55
        fsm_en = 1'b1;
        tick(4);
        v0 = valid_cnt; e0 = ferr_cnt; m0 = msb_cnt; c0 = cyc;
        send_frame(8'h55, 1'b1);
        tick(20);
        check("f55_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("f55_data",        32'(o_data),         32'h55);
        check("f55_ferr_count",  32'(ferr_cnt - e0),  32'd0);
        check("f55_msb_count",   32'(msb_cnt - m0),   32'd1);
        check("f55_latency_ok",
              32'((last_valid_cyc - c0 >= 145) && (last_valid_cyc - c0 <= 165)), 32'd1);

        // Bad stop bit on 0xA3
        v0 = valid_cnt; e0 = ferr_cnt;
        send_frame(8'hA3, 1'b0);
        tick(20);
        check("fA3_ferr_count",  32'(ferr_cnt - e0),  32'd1);
        check("fA3_valid_count", 32'(valid_cnt - v0), 32'd0);
        check("fA3_data_held",   32'(o_data),         32'h55);
`ifdef RX_ERROR_COUNT_EN
        check("fA3_error_count", 32'(o_error_count),  32'd1);
`endif

        // Reset part-way through the data bits, then a clean 0x0F frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i >= 2);
        rst_l = 1'b0;
        rx    = 1'b1;
        tick(1);
        check("midrst_data",   32'(o_data),       32'h00);
        check("midrst_valid",  32'(o_data_valid), 32'd0);
        check("midrst_equal",  32'(o_equal),      32'd0);
        check("midrst_o_RX",   32'(o_RX),         32'd1);
`ifdef RX_ERROR_COUNT_EN
        check("midrst_error_count", 32'(o_error_count), 32'd0);
`endif
        tick(3);
        rst_l = 1'b1;
        tick(4);
        v0 = valid_cnt; e0 = ferr_cnt;
        send_frame(8'h0F, 1'b1);
        tick(20);
        check("f0F_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("f0F_data",        32'(o_data),         32'h0F);
        check("f0F_ferr_count",  32'(ferr_cnt - e0),  32'd0);

`ifdef RX_ERROR_COUNT_EN
        // Saturation of the framing-error counter
        e0 = ferr_cnt;
        for (int f = 0; f < 260; f++) begin
            send_frame(8'h00, 1'b0);
            tick(16);
        end
        check("sat_ferr_count",  32'(ferr_cnt - e0),  32'd260);
        check("sat_error_count", 32'(o_error_count),  32'd255);
        rst_l = 1'b0;
        tick(1);
        check("sat_reset_count", 32'(o_error_count),  32'd0);
        rst_l = 1'b1;
        tick(2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
